branch_resolve: RTL and testbench

BRANCH_RESOLVE -- requirements
Module: branch_resolve

---
 rtl/branch_resolve.sv | 155 +++++++++++++++
 tb/tb_branch_resolve.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch/jump resolution: taken decode, redirect target, flush window.
// Optional stats counters under BRANCH_RESOLVE_STATS_EN.
module branch_resolve #(
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              stall,
    input  logic              is_branch,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic [2:0]        funct3,
    input  logic              BrEQ,
    input  logic              BrLT,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs1,
    output logic              BrUN,
    output logic              pc_sel,
    output logic [DATA_W-1:0] target,
    output logic              flush,
    output logic              misalign,
    output logic              illegal
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [31:0]       br_cnt,
    output logic [31:0]       taken_cnt
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [DATA_W-1:0] LSB_CLR = ~DATA_W'(1);

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              pc_sel_q, pc_sel_d;
    logic              mis_q, mis_d;
    logic              ill_q, ill_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;

    logic              accept;
    logic              taken;
    logic              bad_f3;
    logic [DATA_W-1:0] tgt_pc;
    logic [DATA_W-1:0] tgt_jr;
    logic [DATA_W-1:0] tgt;

    assign BrUN   = is_branch & funct3[1];
    assign tgt_pc = pc_in + imm;
    assign tgt_jr = (rs1 + imm) & LSB_CLR;
    assign accept = valid_in & ~stall & (state_q == IDLE);

    always_comb begin
        taken  = 1'b0;
        bad_f3 = 1'b0;
        tgt    = tgt_pc;
        unique case (1'b1)
            is_jal: taken = 1'b1;
            is_jalr: begin
                taken = 1'b1;
                tgt   = tgt_jr;
            end
            is_branch: begin
                unique case (funct3)
                    3'b000:         taken  = BrEQ;
                    3'b001:         taken  = ~BrEQ;
                    3'b100, 3'b110: taken  = BrLT;
                    3'b101, 3'b111: taken  = ~BrLT;
                    3'b010, 3'b011: bad_f3 = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pc_sel_d = 1'b0;
        mis_d    = 1'b0;
        ill_d    = 1'b0;
        tgt_d    = tgt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ill_d = bad_f3;
                    // Bit 1 set means a non-4-byte-aligned target: trap, no redirect
                    if (taken && tgt[1]) begin
                        mis_d = 1'b1;
                    end else if (taken) begin
                        pc_sel_d = 1'b1;
                        tgt_d    = tgt;
                        state_d  = FLUSH;
                        cnt_d    = CNT_INIT;
                    end
                end
            end
            FLUSH: begin
                if (cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 3'd0;
            pc_sel_q <= 1'b0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_sel_q <= pc_sel_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            tgt_q    <= tgt_d;
        end
    end

    assign pc_sel   = pc_sel_q;
    assign target   = tgt_q;
    assign flush    = (state_q == FLUSH);
    assign misalign = mis_q;
    assign illegal  = ill_q;

`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0] br_cnt_q;
    logic [31:0] tk_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
        end else begin
            if (accept && is_branch) br_cnt_q <= br_cnt_q + 32'd1;
            if (pc_sel_d)            tk_cnt_q <= tk_cnt_q + 32'd1;
        end
    end

    assign br_cnt    = br_cnt_q;
    assign taken_cnt = tk_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed cases plus random traffic against a cycle-level reference model.
module tb_branch_resolve;
    localparam int W  = 32;
    localparam int FC = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in, stall, is_branch, is_jal, is_jalr;
    logic [2:0]   funct3;
    logic         BrEQ, BrLT;
    logic [W-1:0] pc_in, imm, rs1;
    logic         BrUN, pc_sel, flush, misalign, illegal;
    logic [W-1:0] target;
`ifdef BRANCH_RESOLVE_STATS_EN
    logic [31:0]  br_cnt, taken_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int           m_left;
    logic [W-1:0] m_tgt;
    int           m_br, m_tk;

    always #5 clk = ~clk;

    branch_resolve #(.DATA_W(W), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall),
        .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
        .funct3(funct3), .BrEQ(BrEQ), .BrLT(BrLT), .pc_in(pc_in),
        .imm(imm), .rs1(rs1), .BrUN(BrUN), .pc_sel(pc_sel),
        .target(target), .flush(flush), .misalign(misalign),
        .illegal(illegal)
`ifdef BRANCH_RESOLVE_STATS_EN
        , .br_cnt(br_cnt), .taken_cnt(taken_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic s, input int cls,
                       input logic [2:0] f3, input logic eq, input logic lt,
                       input logic [W-1:0] p, input logic [W-1:0] i,
                       input logic [W-1:0] r);
        valid_in  = v;
        stall     = s;
        is_branch = (cls == 1);
        is_jal    = (cls == 2);
        is_jalr   = (cls == 3);
        funct3    = f3;
        BrEQ      = eq;
        BrLT      = lt;
        pc_in     = p;
        imm       = i;
        rs1       = r;
    endtask

    task automatic model_reset();
        m_left = 0;
        m_tgt  = '0;
        m_br   = 0;
        m_tk   = 0;
    endtask

    // One clock: predict from the current inputs, then check after the edge.
    task automatic step(input string tag);
        logic         acc, tk, ill, e_pc, e_mis, e_ill;
        logic [W-1:0] t;
        #1;
        chk({tag, "_brun"}, BrUN, is_branch && funct3[1]);
        acc = valid_in && !stall && (m_left == 0);
        tk = 1'b0;
        ill = 1'b0;
        t = pc_in + imm;
        if (is_jal) tk = 1'b1;
        if (is_jalr) begin
            tk = 1'b1;
            t  = (rs1 + imm) / 2 * 2;
        end
        if (is_branch) begin
            case (funct3)
                3'd0: tk = BrEQ;
                3'd1: tk = !BrEQ;
                3'd4, 3'd6: tk = BrLT;
                3'd5, 3'd7: tk = !BrLT;
                default: ill = 1'b1;
            endcase
        end
        e_pc  = acc && tk && (t % 4 < 2);
        e_mis = acc && tk && (t % 4 >= 2);
        e_ill = acc && ill;
        if (acc && is_branch) m_br++;
        if (m_left > 0) m_left--;
        if (e_pc) begin
            m_left = FC;
            m_tgt  = t;
            m_tk++;
        end
        @(posedge clk);
        #1;
        chk({tag, "_pcsel"}, pc_sel, e_pc);
        chk({tag, "_flush"}, flush, m_left > 0);
        chk({tag, "_mis"}, misalign, e_mis);
        chk({tag, "_ill"}, illegal, e_ill);
        chk({tag, "_tgt"}, target, m_tgt);
`ifdef BRANCH_RESOLVE_STATS_EN
        chk({tag, "_brcnt"}, br_cnt, m_br);
        chk({tag, "_tkcnt"}, taken_cnt, m_tk);
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drv(0, 0, 0, 3'd0, 0, 0, '0, '0, '0);
            step("idle");
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 3'd0, 0, 0, '0, '0, '0);
        model_reset();
        #12;
        chk("rst_pcsel", pc_sel, 0);
        chk("rst_flush", flush, 0);
        chk("rst_mis", misalign, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_tgt", target, 0);
        rst_n = 1'b1;

        drv(1, 0, 1, 3'b000, 1, 0, 32'h100, 32'h20, '0);
        step("c1");
        chk("c1_target", target, 32'h120);
        chk("c1_pcsel1", pc_sel, 1);
        drv(1, 0, 2, 3'b000, 0, 0, 32'h400, 32'h8, '0);
        step("c1_sq1");
        chk("c1_flush2", flush, 1);
        drv(1, 0, 2, 3'b000, 0, 0, 32'h400, 32'h8, '0);
        step("c1_sq2");
        chk("c1_flush_end", flush, 0);
        chk("c1_tgt_hold", target, 32'h120);

        drv(1, 0, 1, 3'b110, 0, 0, 32'h200, 32'h40, '0);
        #1;
        chk("c2_brun_comb", BrUN, 1);
        step("c2");
        chk("c2_nopc", pc_sel, 0);

        drv(1, 0, 3, 3'b000, 0, 0, '0, 32'h4, 32'h1001);
        step("c3a");
        chk("c3_target", target, 32'h1004);
        idle(2);
        drv(1, 0, 3, 3'b000, 0, 0, '0, 32'h0, 32'h1002);
        step("c3b");
        chk("c3_mis", misalign, 1);
        idle(1);

        drv(1, 0, 1, 3'b011, 1, 1, 32'h300, 32'h10, '0);
        step("c4");
        chk("c4_ill", illegal, 1);
        idle(1);

        drv(1, 0, 1, 3'b000, 1, 0, 32'h500, 32'h10, '0);
        step("c5a");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("c5_flush_drop", flush, 0);
        chk("c5_pcsel_drop", pc_sel, 0);
        drv(1, 0, 1, 3'b001, 0, 0, 32'h800, 32'h24, '0);
        rst_n = 1'b1;
        step("c5b");
        chk("c5_target", target, 32'h824);
        idle(2);

`ifdef BRANCH_RESOLVE_STATS_EN
        rst_n = 1'b0;
        #1;
        model_reset();
        rst_n = 1'b1;
        drv(1, 0, 1, 3'b000, 1, 0, 32'h100, 32'h8, '0);
        step("c6a");
        idle(2);
        drv(1, 0, 1, 3'b001, 1, 0, 32'h100, 32'h8, '0);
        step("c6b");
        drv(1, 0, 1, 3'b101, 0, 0, 32'h100, 32'hC, '0);
        step("c6c");
        idle(2);
        chk("c6_brcnt", br_cnt, 3);
        chk("c6_tkcnt", taken_cnt, 2);
`endif

        for (int n = 0; n < 400; n++) begin
            drv($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3), 3'($urandom), 1'($urandom),
                1'($urandom), $urandom, $urandom, $urandom);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
